// File: rtl/accel_pkg.sv
// Shared definitions for the multi-channel accelerometer moving-average filter.
// Holds the mode encodings, the controller state type and the default geometry
// used by the filter top level and by the platform glue.
package accel_pkg;

  localparam int DEF_CHANNELS   = 3;
  localparam int DEF_WIDTH      = 16;
  localparam int DEF_LOG2_DEPTH = 3;

  // Runtime mode, sampled with each accepted sample. Code 2'b11 behaves as average.
  localparam logic [1:0] MODE_AVG    = 2'b00;
  localparam logic [1:0] MODE_BYPASS = 2'b01;
  localparam logic [1:0] MODE_FREEZE = 2'b10;

  typedef enum logic [1:0] {
    CLEAR  = 2'd0,
    IDLE   = 2'd1,
    READ   = 2'd2,
    UPDATE = 2'd3
  } state_e;

endpackage

// File: rtl/filt_tap_ram.sv
// Single-channel tap buffer: DEPTH x WIDTH, one write port, one synchronous
// read port. Small enough to map to registers or a block RAM.
// Ports:
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, data appears on rdata one cycle later
//   rdata  - registered read data (old contents on a same-address write)
module filt_tap_ram #(
  parameter int WIDTH      = 16,
  parameter int LOG2_DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [LOG2_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_q [2**LOG2_DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // NOTE: the array has no reset so it can map onto RAM; the controller's
  // CLEAR sequence writes every address before any read is used.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/accel_filter_mc.sv
// Multi-channel moving-average filter. Each channel keeps a circular tap buffer
// of DEPTH samples and a running sum; an accepted sample replaces the oldest tap
// and the channel output becomes the floor average, the raw sample, or is held.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_valid/in_ready - sample handshake; in_ch/in_data/mode qualify the sample
//   clear             - zero all buffers, sums and fill state (taken in IDLE only)
//   out_data          - per-channel filtered values, channel c at [c*WIDTH +: WIDTH]
//   out_valid/out_ch  - one-cycle strobe naming the channel just updated
//   primed            - bit c set once DEPTH samples landed on channel c
//   err_ch            - sticky flag for a sample tagged with a nonexistent channel
module accel_filter_mc
  import accel_pkg::*;
#(
  parameter int CHANNELS   = DEF_CHANNELS,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int LOG2_DEPTH = DEF_LOG2_DEPTH,
  parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CH_W-1:0]           in_ch,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [1:0]                mode,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic                      out_valid,
  output logic [CH_W-1:0]           out_ch,
  output logic [CHANNELS-1:0]       primed,
  output logic                      err_ch
);

  localparam int DEPTH = 2**LOG2_DEPTH;
  localparam int SW    = WIDTH + LOG2_DEPTH;  // running sum cannot overflow
  localparam int FW    = LOG2_DEPTH + 1;      // fill counter reaches DEPTH

  state_e                   state_q, state_d;
  logic [LOG2_DEPTH-1:0]    clr_cnt_q, clr_cnt_d;
  logic [CH_W-1:0]          ch_q, ch_d;
  logic                     ch_ok_q, ch_ok_d;
  logic signed [WIDTH-1:0]  data_q, data_d;
  logic [1:0]               mode_q, mode_d;
  logic [LOG2_DEPTH-1:0]    ptr_q [CHANNELS];
  logic [LOG2_DEPTH-1:0]    ptr_d [CHANNELS];
  logic signed [SW-1:0]     sum_q [CHANNELS];
  logic signed [SW-1:0]     sum_d [CHANNELS];
  logic [FW-1:0]            fill_q [CHANNELS];
  logic [FW-1:0]            fill_d [CHANNELS];
  logic [CHANNELS-1:0]      primed_q, primed_d;
  logic [CHANNELS*WIDTH-1:0] out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [CH_W-1:0]          out_ch_q, out_ch_d;
  logic                     err_q, err_d;
  logic signed [SW-1:0]     avg_full;

  logic [CHANNELS-1:0]      ram_we;
  logic [LOG2_DEPTH-1:0]    ram_waddr [CHANNELS];
  logic [WIDTH-1:0]         ram_wdata;
  logic signed [WIDTH-1:0]  ram_rdata [CHANNELS];

  // Every RAM reads at its own write pointer each cycle, so during UPDATE the
  // oldest tap of the selected channel is already on its read port.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_tap
    filt_tap_ram #(.WIDTH(WIDTH), .LOG2_DEPTH(LOG2_DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we[g]),
      .waddr (ram_waddr[g]),
      .wdata (ram_wdata),
      .raddr (ptr_q[g]),
      .rdata (ram_rdata[g])
    );
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    ch_d        = ch_q;
    ch_ok_d     = ch_ok_q;
    data_d      = data_q;
    mode_d      = mode_q;
    ptr_d       = ptr_q;
    sum_d       = sum_q;
    fill_d      = fill_q;
    primed_d    = primed_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    out_ch_d    = out_ch_q;
    err_d       = err_q;
    avg_full    = '0;
    ram_we      = '0;
    ram_wdata   = '0;
    for (int c = 0; c < CHANNELS; c++) ram_waddr[c] = ptr_q[c];

    unique case (state_q)
      CLEAR: begin
        ram_we   = '1;
        primed_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
          ram_waddr[c] = clr_cnt_q;
          ptr_d[c]     = '0;
          sum_d[c]     = '0;
          fill_d[c]    = '0;
        end
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LOG2_DEPTH'(DEPTH - 1)) begin
          clr_cnt_d = '0;
          state_d   = IDLE;
        end
      end
      IDLE: begin
        // clear has priority; the concurrent sample is left unaccepted.
        if (clear) begin
          state_d = CLEAR;
        end else if (in_valid) begin
          ch_d    = in_ch;
          data_d  = in_data;
          mode_d  = mode;
          ch_ok_d = int'(in_ch) < CHANNELS;
          if (int'(in_ch) >= CHANNELS) err_d = 1'b1;
          state_d = READ;
        end
      end
      READ: state_d = UPDATE;
      UPDATE: begin
        state_d = IDLE;
        for (int c = 0; c < CHANNELS; c++) begin
          if (ch_ok_q && ch_q == CH_W'(c)) begin
            ram_we[c] = 1'b1;
            ram_wdata = data_q;
            ptr_d[c]  = ptr_q[c] + 1'b1;  // power-of-two depth wraps naturally
            sum_d[c]  = sum_q[c] + SW'(data_q) - SW'(ram_rdata[c]);
            if (fill_q[c] != FW'(DEPTH)) fill_d[c] = fill_q[c] + 1'b1;
            primed_d[c] = primed_q[c] | (fill_d[c] == FW'(DEPTH));
            // Arithmetic shift floors toward minus infinity and always fits WIDTH.
            avg_full = sum_d[c] >>> LOG2_DEPTH;
            if (mode_q != MODE_FREEZE) begin
              out_valid_d = 1'b1;
              out_ch_d    = ch_q;
              out_data_d[c*WIDTH +: WIDTH] = (mode_q == MODE_BYPASS) ? data_q
                                                                     : avg_full[WIDTH-1:0];
            end
          end
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      ch_q        <= '0;
      ch_ok_q     <= 1'b0;
      data_q      <= '0;
      mode_q      <= MODE_AVG;
      primed_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      err_q       <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        ptr_q[c]  <= '0;
        sum_q[c]  <= '0;
        fill_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      ch_q        <= ch_d;
      ch_ok_q     <= ch_ok_d;
      data_q      <= data_d;
      mode_q      <= mode_d;
      primed_q    <= primed_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      err_q       <= err_d;
      ptr_q       <= ptr_d;
      sum_q       <= sum_d;
      fill_q      <= fill_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign primed    = primed_q;
  assign err_ch    = err_q;

endmodule

// File: tb/tb_accel_filter_mc.sv
// Testbench for accel_filter_mc with the default geometry (3 channels, 16-bit,
// 8-tap window). The reference model keeps the full history of accepted samples
// per channel and averages the most recent eight with floor division.
module tb_accel_filter_mc;

  localparam int CH  = 3;
  localparam int W   = 16;
  localparam int CHW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CHW-1:0]  in_ch = '0;
  logic [W-1:0]    in_data = '0;
  logic [1:0]      mode = 2'b00;
  logic            clear = 1'b0;
  logic [CH*W-1:0] out_data;
  logic            out_valid;
  logic [CHW-1:0]  out_ch;
  logic [CH-1:0]   primed;
  logic            err_ch;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  int hist [CH][$];
  int exp_out [CH];
  bit err_m;

  accel_filter_mc #(.CHANNELS(CH), .WIDTH(W), .LOG2_DEPTH(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .mode      (mode),
    .clear     (clear),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .primed    (primed),
    .err_ch    (err_ch)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic int floor_div8(input int s);
    int q;
    q = s / 8;
    if (s < 0 && (s % 8) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int model_avg(input int c);
    int s = 0;
    int n = hist[c].size();
    for (int i = 0; i < 8 && i < n; i++) s += hist[c][n-1-i];
    return floor_div8(s);
  endfunction

  function automatic logic [CH*W-1:0] exp_bus();
    logic [CH*W-1:0] b;
    for (int c = 0; c < CH; c++) b[c*W +: W] = W'(exp_out[c]);
    return b;
  endfunction

  function automatic logic [CH-1:0] exp_primed();
    logic [CH-1:0] p;
    for (int c = 0; c < CH; c++) p[c] = (hist[c].size() >= 8);
    return p;
  endfunction

  function automatic void model_clear_taps();
    for (int c = 0; c < CH; c++) hist[c].delete();
  endfunction

  function automatic void model_reset();
    model_clear_taps();
    for (int c = 0; c < CH; c++) exp_out[c] = 0;
    err_m = 1'b0;
  endfunction

  // Counts consecutive negedges (starting with the current one) where in_ready
  // is low; also reports whether out_valid was seen during that window.
  task automatic count_not_ready(output int zeros, output bit saw_valid);
    zeros = 0;
    saw_valid = 1'b0;
    while (in_ready === 1'b0 && zeros < 30) begin
      if (out_valid !== 1'b0) saw_valid = 1'b1;
      zeros++;
      @(negedge clk);
    end
  endtask

  // Presents one sample, updates the model, and checks the response window.
  task automatic send(input int ch, input int data, input logic [1:0] md);
    int waited = 0;
    bit exp_valid = 1'b0;
    logic signed [W-1:0] d16;
    d16 = data[W-1:0];
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_timeout: in_ready=%b required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_ch    = CHW'(ch);
    in_data  = d16;
    mode     = md;
    @(negedge clk);
    in_valid = 1'b0;

    if (ch >= CH) begin
      err_m = 1'b1;
    end else begin
      hist[ch].push_back(int'(d16));
      if (md != 2'b10) begin
        exp_valid   = 1'b1;
        exp_out[ch] = (md == 2'b01) ? int'(d16) : model_avg(ch);
      end
    end

    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL early_valid_t1: out_valid=%b required 0 (ch=%0d)", out_valid, ch);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL early_valid_t2: out_valid=%b required 0 (ch=%0d)", out_valid, ch);
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== exp_valid) begin
      n_bad++;
      $display("FAIL out_valid_t3: out_valid=%b required %b (ch=%0d mode=%0d)",
               out_valid, exp_valid, ch, md);
    end
    n_cmp++;
    if (out_data !== exp_bus()) begin
      n_bad++;
      $display("FAIL out_data: got %h required %h (ch=%0d data=%0d mode=%0d)",
               out_data, exp_bus(), ch, d16, md);
    end
    n_cmp++;
    if (primed !== exp_primed()) begin
      n_bad++;
      $display("FAIL primed: got %b required %b", primed, exp_primed());
    end
    n_cmp++;
    if (err_ch !== err_m) begin
      n_bad++;
      $display("FAIL err_ch: got %b required %b", err_ch, err_m);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_t3: in_ready=%b required 1", in_ready);
    end
    if (exp_valid) begin
      n_cmp++;
      if (out_ch !== CHW'(ch)) begin
        n_bad++;
        $display("FAIL out_ch: got %0d required %0d", out_ch, ch);
      end
    end
  endtask

  task automatic test_reset();
    int zeros;
    bit saw;
    reset = 1'b1;
    in_valid = 1'b0;
    clear = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    reset = 1'b0;
    count_not_ready(zeros, saw);
    n_cmp++;
    if (zeros != 8) begin
      n_bad++;
      $display("FAIL reset_clear_len: in_ready low for %0d cycles, required 8", zeros);
    end
    n_cmp++;
    if (saw) begin
      n_bad++;
      $display("FAIL reset_valid: out_valid pulsed during CLEAR, required none");
    end
    n_cmp++;
    if ({out_data, out_valid, out_ch, primed, err_ch} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: data=%h valid=%b ch=%0d primed=%b err=%b required all 0",
               out_data, out_valid, out_ch, primed, err_ch);
    end
  endtask

  task automatic test_first_sample();
    send(0, 800, 2'b00);   // 800/8 = 100, not primed
  endtask

  task automatic test_ramp();
    for (int i = 0; i < 8; i++) send(1, -8, 2'b00);  // -1 .. -8, primed on 8th
    send(1, 8, 2'b00);                                // -56+8 = -48 -> -6
    send(2, -1, 2'b11);                               // floor(-1/8) = -1
  endtask

  task automatic test_modes();
    send(0, 1234, 2'b01);  // bypass
    send(0, 500, 2'b10);   // freeze: held, no strobe
    send(0, 0, 2'b00);     // (800+1234+500+0)/8 -> 316
  endtask

  task automatic test_bad_channel();
    send(3, 777, 2'b00);
    send(2, 16, 2'b00);    // neighbours keep working, err stays set
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++)
      send(int'($urandom_range(0, 3)), int'($urandom), 2'($urandom_range(0, 3)));
  endtask

  task automatic test_clear();
    int zeros;
    bit saw;
    logic [CH*W-1:0] held;
    while (in_ready !== 1'b1 && zeros < 20) begin
      @(negedge clk);
      zeros++;
    end
    held = exp_bus();
    clear = 1'b1;
    in_valid = 1'b1;
    in_ch = 2'd0;
    in_data = 16'd9999;
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
    model_clear_taps();
    count_not_ready(zeros, saw);
    n_cmp++;
    if (zeros != 8) begin
      n_bad++;
      $display("FAIL clear_len: in_ready low for %0d cycles, required 8", zeros);
    end
    n_cmp++;
    if (saw) begin
      n_bad++;
      $display("FAIL clear_valid: out_valid pulsed across clear, required none");
    end
    n_cmp++;
    if (primed !== '0) begin
      n_bad++;
      $display("FAIL clear_primed: got %b required 0", primed);
    end
    n_cmp++;
    if (out_data !== held) begin
      n_bad++;
      $display("FAIL clear_out_data: got %h required %h", out_data, held);
    end
    send(0, 80, 2'b00);    // fresh window: 80/8 = 10
  endtask

  task automatic test_reset_mid_flight();
    int zeros = 0;
    bit saw;
    while (in_ready !== 1'b1 && zeros < 20) begin
      @(negedge clk);
      zeros++;
    end
    in_valid = 1'b1;
    in_ch = 2'd1;
    in_data = 16'd4000;
    mode = 2'b01;
    @(negedge clk);        // sample accepted, now in READ
    in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    count_not_ready(zeros, saw);
    n_cmp++;
    if (zeros != 8) begin
      n_bad++;
      $display("FAIL midreset_clear_len: in_ready low for %0d cycles, required 8", zeros);
    end
    n_cmp++;
    if (saw) begin
      n_bad++;
      $display("FAIL midreset_valid: out_valid pulsed, required none");
    end
    n_cmp++;
    if ({out_data, primed, err_ch} !== '0) begin
      n_bad++;
      $display("FAIL midreset_outputs: data=%h primed=%b err=%b required 0",
               out_data, primed, err_ch);
    end
    send(1, -24, 2'b00);   // -24/8 = -3 on the freshly cleared buffer
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_sample();
    test_ramp();
    test_modes();
    test_bad_channel();
    test_random();
    test_clear();
    test_reset_mid_flight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
